bf16_fp8_drain: RTL

//   Drain/requantize stage at the PE array output. Captures one column of N BF16 accumulator results
//   in a single handshake, converts each to FP8 E4M3 (the PE input format), and streams the results
//   out one per cycle over a valid/ready interface. Feeds results back to the activation buffer so the

---
 rtl/bf16_fp8_drain_if.sv | 28 ++
 rtl/bf16_fp8_drain.sv | 115 +++++++++++
 2 files changed

// File: rtl/bf16_fp8_drain_if.sv
// Column-capture / lane-stream bus for the BF16 -> FP8 E4M3 drain stage.
// The master side is the producer/consumer environment; the slave side is the drain block.
interface bf16_fp8_drain_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [16*N-1:0]   in_data;
    logic signed [5:0] in_scale;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              sat_sticky;
    logic              sat_clr;

    modport master (
        output in_valid, in_data, in_scale, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, out_idx, out_last, sat_sticky
    );

    modport slave (
        input  in_valid, in_data, in_scale, out_ready, sat_clr,
        output in_ready, out_valid, out_data, out_idx, out_last, sat_sticky
    );
endinterface

// File: rtl/bf16_fp8_drain.sv
// Captures a column of N BF16 accumulator results and streams them out one lane per cycle,
// requantized to FP8 E4M3 with a per-column exponent adjust.
module bf16_fp8_drain #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input logic               clk,
    input logic               rst,
    bf16_fp8_drain_if.slave   bus
);
    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e            r_state;
    logic [15:0]       r_lanes [N];
    logic signed [5:0] r_scale;
    logic [7:0]        r_out_data;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_out_valid;
    logic              r_out_last;
    logic              r_out_sat;
    logic              r_sat_sticky;

    logic              w_in_ready;
    logic              w_capture;
    logic              w_accept;
    logic              w_load;
    logic [IDX_W-1:0]  w_ld_idx;
    logic [15:0]       w_bf;
    logic signed [9:0] w_ef;
    logic signed [9:0] w_ef_rnd;
    logic [3:0]        w_mant_rnd;
    logic              w_rnd_up;
    logic [7:0]        w_conv_data;
    logic              w_conv_sat;

    assign w_in_ready = (r_state == StIdle) | (r_out_valid & r_out_last & bus.out_ready);
    assign w_capture  = bus.in_valid & w_in_ready;
    assign w_accept   = r_out_valid & bus.out_ready;
    // After a capture the output register is empty, so lane 0 loads on the following edge.
    assign w_load     = (r_state == StDrain) & (~r_out_valid | (bus.out_ready & ~r_out_last));
    assign w_ld_idx   = r_out_valid ? r_out_idx + 1'b1 : '0;
    assign w_bf       = r_lanes[w_ld_idx];

    always_comb begin
        w_rnd_up    = w_bf[3] & ((|w_bf[2:0]) | w_bf[4]);
        w_mant_rnd  = {1'b0, w_bf[6:4]} + {3'b000, w_rnd_up};
        w_ef        = {2'b00, w_bf[14:7]} - 10'd120 + {{4{r_scale[5]}}, r_scale};
        w_ef_rnd    = w_ef + {9'd0, w_mant_rnd[3]};
        w_conv_sat  = 1'b0;
        w_conv_data = {w_bf[15], 7'h00};
        if (w_bf[14:7] == 8'hFF) begin
            w_conv_sat  = 1'b1;
            w_conv_data = {w_bf[15], (w_bf[6:0] != 7'h00) ? 7'h7F : 7'h7E};
        end else if ((w_bf[14:7] == 8'h00) || (w_ef <= 10'sd0)) begin
            w_conv_data = {w_bf[15], 7'h00};
        end else if ((w_ef_rnd > 10'sd15) ||
                     ((w_ef_rnd == 10'sd15) && (w_mant_rnd[2:0] == 3'b111))) begin
            w_conv_sat  = 1'b1;
            w_conv_data = {w_bf[15], 7'h7E};
        end else begin
            w_conv_data = {w_bf[15], w_ef_rnd[3:0], w_mant_rnd[2:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_idx    <= '0;
            r_out_last   <= 1'b0;
            r_out_sat    <= 1'b0;
            r_sat_sticky <= 1'b0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < N; i++) begin
                    r_lanes[i] <= bus.in_data[16*i +: 16];
                end
                r_scale <= bus.in_scale;
            end
            if (w_accept & r_out_sat) begin
                r_sat_sticky <= 1'b1;
            end else if (bus.sat_clr) begin
                r_sat_sticky <= 1'b0;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_capture) r_state <= StDrain;
                end
                StDrain: begin
                    if (w_accept & r_out_last) begin
                        r_out_valid <= 1'b0;
                        r_out_idx   <= '0;
                        r_out_last  <= 1'b0;
                        if (!w_capture) r_state <= StIdle;
                    end else if (w_load) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_conv_data;
                        r_out_idx   <= w_ld_idx;
                        r_out_last  <= (w_ld_idx == IDX_W'(N - 1));
                        r_out_sat   <= w_conv_sat;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_idx    = r_out_idx;
    assign bus.out_last   = r_out_last;
    assign bus.sat_sticky = r_sat_sticky;
endmodule
